// File: rtl/control_reg_pkg.sv
// control_reg_pkg
// Shared definitions for the multi-bit firmware control register:
//   - per-bit output mode encodings (2 bits per control bit in ModeVec)
//   - width limits for the control vector and the pulse counters
package control_reg_pkg;

  localparam int CTRL_MAX_WIDTH   = 32;
  localparam int CTRL_PULSE_CNT_W = 8;

  typedef enum logic [1:0] {
    CTRL_MODE_DIRECT = 2'd0,
    CTRL_MODE_SYNC   = 2'd1,
    CTRL_MODE_TOGGLE = 2'd2,
    CTRL_MODE_PULSE  = 2'd3
  } ctrl_mode_e;

endpackage

// File: rtl/control_reg_pulse_bit.sv
// control_reg_pulse_bit
// One PULSE-mode control bit: a pending flag set by firmware writes and a
// down-counter loaded with PulseWidth when the pending request is committed.
// Ports:
//   clock  - single clock
//   reset  - synchronous, active-low
//   set    - write strobe for this bit with data=1 (arms the pending flag)
//   commit - shadow-to-active commit strobe
//   pulse  - high while the counter is nonzero
module control_reg_pulse_bit
  import control_reg_pkg::*;
#(
  parameter int PulseWidth = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic set,
  input  logic commit,
  output logic pulse
);

  localparam logic [CTRL_PULSE_CNT_W-1:0] RELOAD = CTRL_PULSE_CNT_W'(PulseWidth);

  logic                        pending;
  logic                        pending_nxt;
  logic [CTRL_PULSE_CNT_W-1:0] count;

  // A write in the same cycle as a commit is seen by that commit.
  assign pending_nxt = pending | set;

  always_ff @(posedge clock) begin
    if (!reset) begin
      pending <= 1'b0;
      count   <= '0;
    end else if (commit && pending_nxt) begin
      // Reload even when still counting: retrigger without a low gap.
      pending <= 1'b0;
      count   <= RELOAD;
    end else begin
      pending <= commit ? 1'b0 : pending_nxt;
      if (count != '0) count <= count - CTRL_PULSE_CNT_W'(1);
    end
  end

  assign pulse = (count != '0);

endmodule

// File: rtl/control_reg_multi.sv
// control_reg_multi
// Firmware-writable control register with 1..32 bits, per-bit output mode
// (DIRECT, SYNC, TOGGLE, PULSE) and a shadow/active double buffer so that
// several bits can be committed atomically.
// Ports:
//   clock      - single clock
//   reset      - synchronous, active-low
//   wr_en      - one-cycle write strobe
//   wr_data    - write value
//   wr_mask    - per-bit write enable (1 = bit written)
//   load       - commit shadow to active (ignored when AutoLoad=1)
//   control    - control outputs
//   rd_data    - shadow readback (PULSE bits read 0)
//   pulse_busy - any PULSE counter nonzero
module control_reg_multi
  import control_reg_pkg::*;
#(
  parameter int                        Width      = 8,
  parameter logic [CTRL_MAX_WIDTH-1:0] InitValue  = '0,
  parameter logic [2*Width-1:0]        ModeVec    = '0,
  parameter int                        PulseWidth = 1,
  parameter bit                        AutoLoad   = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [Width-1:0] wr_data,
  input  logic [Width-1:0] wr_mask,
  input  logic             load,
  output logic [Width-1:0] control,
  output logic [Width-1:0] rd_data,
  output logic             pulse_busy
);

  if (Width < 1 || Width > CTRL_MAX_WIDTH) begin : g_chk_width
    $error("control_reg_multi: Width %0d outside 1..%0d", Width, CTRL_MAX_WIDTH);
  end
  if (PulseWidth < 1 || PulseWidth > 255) begin : g_chk_pulse
    $error("control_reg_multi: PulseWidth %0d outside 1..255", PulseWidth);
  end
  if ($bits(ModeVec) != 2 * Width) begin : g_chk_mode
    $error("control_reg_multi: ModeVec must be 2*Width bits wide");
  end

  function automatic logic [Width-1:0] mode_mask(input ctrl_mode_e m);
    logic [Width-1:0] r;
    r = '0;
    for (int i = 0; i < Width; i++) r[i] = (ModeVec[2*i +: 2] == m);
    return r;
  endfunction

  localparam logic [Width-1:0] DIRECT_MASK = mode_mask(CTRL_MODE_DIRECT);
  localparam logic [Width-1:0] SYNC_MASK   = mode_mask(CTRL_MODE_SYNC);
  localparam logic [Width-1:0] TOGGLE_MASK = mode_mask(CTRL_MODE_TOGGLE);
  localparam logic [Width-1:0] PULSE_MASK  = mode_mask(CTRL_MODE_PULSE);
  localparam logic [Width-1:0] ACTIVE_OUT  = ~(PULSE_MASK | SYNC_MASK);
  localparam logic [Width-1:0] INIT_ACTIVE = InitValue[Width-1:0] & ~PULSE_MASK;
  localparam logic [Width-1:0] INIT_SYNC   = InitValue[Width-1:0];

  logic [Width-1:0] shadow;
  logic [Width-1:0] active;
  logic [Width-1:0] sync_q;
  logic [Width-1:0] shadow_nxt;
  logic [Width-1:0] wr_bits;
  logic [Width-1:0] load_bits;
  logic [Width-1:0] flip_bits;
  logic [Width-1:0] pulse_vec;
  logic             commit;

  assign commit    = AutoLoad || load;
  assign wr_bits   = wr_en ? wr_mask : '0;
  assign load_bits = wr_bits & (DIRECT_MASK | SYNC_MASK);
  assign flip_bits = wr_bits & TOGGLE_MASK & wr_data;

  // PULSE bits are never loaded or flipped, so they stay 0 in the shadow.
  assign shadow_nxt = ((shadow & ~load_bits) | (wr_data & load_bits)) ^ flip_bits;

  // Shadow/active double buffer; the commit uses the post-write shadow.
  always_ff @(posedge clock) begin
    if (!reset) begin
      shadow <= INIT_ACTIVE;
      active <= INIT_ACTIVE;
      sync_q <= INIT_SYNC;
    end else begin
      shadow <= shadow_nxt;
      if (commit) active <= shadow_nxt;
      sync_q <= active;
    end
  end

  for (genvar i = 0; i < Width; i++) begin : g_bit
    if (PULSE_MASK[i]) begin : g_pulse
      control_reg_pulse_bit #(
        .PulseWidth(PulseWidth)
      ) u_pulse (
        .clock  (clock),
        .reset  (reset),
        .set    (wr_en & wr_mask[i] & wr_data[i]),
        .commit (commit),
        .pulse  (pulse_vec[i])
      );
    end else begin : g_plain
      assign pulse_vec[i] = 1'b0;
    end
  end

  assign control    = (active & ACTIVE_OUT) | (sync_q & SYNC_MASK) | pulse_vec;
  assign rd_data    = shadow;
  assign pulse_busy = |pulse_vec;

endmodule

// File: tb/tb_control_reg_multi.sv
// Bench for control_reg_multi: two instances sharing stimulus, one with
// AutoLoad=0 (a) and one with AutoLoad=1 (b), both with mixed bit modes.
module tb_control_reg_multi;

  localparam logic [15:0] MODES = 16'h1B63; // b7..b0: D S T P S T D P
  localparam int          PW    = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic [7:0] wr_mask = '0;
  logic       load = 1'b0;
  logic [7:0] ctrl_a, rd_a, ctrl_b, rd_b;
  logic       busy_a, busy_b;
  logic [33:0] got, exp_all;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  control_reg_multi #(.Width(8), .InitValue(32'hA5), .ModeVec(MODES),
                      .PulseWidth(PW), .AutoLoad(1'b0)) dut_a (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .wr_mask(wr_mask), .load(load), .control(ctrl_a), .rd_data(rd_a),
    .pulse_busy(busy_a));

  control_reg_multi #(.Width(8), .InitValue(32'hA5), .ModeVec(MODES),
                      .PulseWidth(PW), .AutoLoad(1'b1)) dut_b (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .wr_mask(wr_mask), .load(load), .control(ctrl_b), .rd_data(rd_b),
    .pulse_busy(busy_b));

  assign got = {ctrl_a, rd_a, busy_a, ctrl_b, rd_b, busy_b};

  // Reference model: per-bit integer state, index 0 = instance a, 1 = b.
  int         mode_of [8] = '{3, 0, 2, 1, 3, 2, 1, 0};
  logic [7:0] init_val = 8'hA5;
  int sh [2][8];
  int act [2][8];
  int syn [2][8];
  int pend [2][8];
  int cnt [2][8];

  task automatic model_step();
    logic [7:0] ec [2];
    logic [7:0] er [2];
    logic       eb [2];
    int  nsh, npend;
    bit  w, cm;
    for (int k = 0; k < 2; k++) begin
      cm = (k == 1) || load;
      eb[k] = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (!reset) begin
          sh[k][i]   = (mode_of[i] == 3) ? 0 : int'(init_val[i]);
          act[k][i]  = sh[k][i];
          syn[k][i]  = int'(init_val[i]);
          pend[k][i] = 0;
          cnt[k][i]  = 0;
        end else begin
          nsh   = sh[k][i];
          npend = pend[k][i];
          w     = wr_en && wr_mask[i];
          case (mode_of[i])
            0, 1: if (w) nsh = int'(wr_data[i]);
            2:    if (w && wr_data[i]) nsh = 1 - nsh;
            default: if (w && wr_data[i]) npend = 1;
          endcase
          if (mode_of[i] == 3) begin
            if (cm && npend == 1) begin
              cnt[k][i] = PW;
              npend = 0;
            end else if (cnt[k][i] > 0) begin
              cnt[k][i] = cnt[k][i] - 1;
            end
          end
          syn[k][i] = act[k][i];
          if (cm) act[k][i] = nsh;
          sh[k][i]   = nsh;
          pend[k][i] = npend;
        end
        case (mode_of[i])
          3:       ec[k][i] = (cnt[k][i] > 0);
          1:       ec[k][i] = (syn[k][i] != 0);
          default: ec[k][i] = (act[k][i] != 0);
        endcase
        er[k][i] = (mode_of[i] == 3) ? 1'b0 : (sh[k][i] != 0);
        if (cnt[k][i] > 0) eb[k] = 1'b1;
      end
    end
    exp_all = {ec[0], er[0], eb[0], ec[1], er[1], eb[1]};
  endtask

  task automatic drive(input logic r, input logic we, input logic [7:0] d,
                       input logic [7:0] m, input logic ld);
    reset = r; wr_en = we; wr_data = d; wr_mask = m; load = ld;
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b1, 8'h5A, 8'hFF, 1'b1);
    drive(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1);
    total++; if (ctrl_a !== 8'hA4) begin bad++; $display("FAIL reset_ctrl_a got=%h want=a4", ctrl_a); end
    total++; if (ctrl_b !== 8'hA4) begin bad++; $display("FAIL reset_ctrl_b got=%h want=a4", ctrl_b); end
    total++; if (rd_a !== 8'hA4) begin bad++; $display("FAIL reset_rd_a got=%h want=a4", rd_a); end
    total++; if ({busy_a, busy_b} !== 2'b00) begin bad++; $display("FAIL reset_busy got=%b want=00", {busy_a, busy_b}); end
    total++; if (got !== exp_all) begin bad++; $display("FAIL reset_model got=%h want=%h", got, exp_all); end
  endtask

  task automatic test_direct_sync();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b0);
    total++; if ({ctrl_b[1], ctrl_b[3], ctrl_b[6]} !== 3'b100) begin bad++; $display("FAIL direct_n1 got=%b want=100", {ctrl_b[1], ctrl_b[3], ctrl_b[6]}); end
    total++; if (got !== exp_all) begin bad++; $display("FAIL direct_model1 got=%h want=%h", got, exp_all); end
    drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    total++; if ({ctrl_b[3], ctrl_b[6]} !== 2'b11) begin bad++; $display("FAIL sync_n2 got=%b want=11", {ctrl_b[3], ctrl_b[6]}); end
    total++; if (got !== exp_all) begin bad++; $display("FAIL sync_model2 got=%h want=%h", got, exp_all); end
  endtask

  task automatic test_toggle_mask();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(1'b1, 1'b1, 8'hFF, 8'h24, 1'b0);
    total++; if (rd_b !== 8'h80) begin bad++; $display("FAIL toggle_first got=%h want=80", rd_b); end
    total++; if (ctrl_b[2] !== 1'b0) begin bad++; $display("FAIL toggle_ctrl got=%b want=0", ctrl_b[2]); end
    drive(1'b1, 1'b1, 8'hFF, 8'h24, 1'b0);
    total++; if (rd_a !== 8'hA4) begin bad++; $display("FAIL toggle_second got=%h want=a4", rd_a); end
    total++; if (got !== exp_all) begin bad++; $display("FAIL toggle_model got=%h want=%h", got, exp_all); end
  endtask

  task automatic test_pulse_retrigger();
    logic [6:0] we_seq;
    we_seq = 7'b0000101;
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    for (int k = 0; k < 7; k++) begin
      drive(1'b1, we_seq[k], 8'h01, 8'h01, 1'b0);
      total++; if ({ctrl_b[0], busy_b} !== {2{k < 6}}) begin bad++; $display("FAIL pulse_cycle%0d got=%b want=%b", k + 1, {ctrl_b[0], busy_b}, {2{k < 6}}); end
      total++; if (got !== exp_all) begin bad++; $display("FAIL pulse_model%0d got=%h want=%h", k + 1, got, exp_all); end
    end
  endtask

  task automatic test_double_buffer();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(1'b1, 1'b1, 8'h3C, 8'hFF, 1'b0);
    total++; if ({ctrl_a, rd_a} !== 16'hA4_08) begin bad++; $display("FAIL dbuf_hold got=%h want=a408", {ctrl_a, rd_a}); end
    drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    total++; if (ctrl_a !== 8'hA4) begin bad++; $display("FAIL dbuf_wait got=%h want=a4", ctrl_a); end
    drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
    total++; if (ctrl_a !== 8'h10) begin bad++; $display("FAIL dbuf_load1 got=%h want=10", ctrl_a); end
    drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    total++; if (ctrl_a !== 8'h18) begin bad++; $display("FAIL dbuf_load2 got=%h want=18", ctrl_a); end
    drive(1'b1, 1'b1, 8'h80, 8'h80, 1'b1);
    total++; if (ctrl_a[7] !== 1'b1) begin bad++; $display("FAIL dbuf_wr_load got=%b want=1", ctrl_a[7]); end
    total++; if (got !== exp_all) begin bad++; $display("FAIL dbuf_model got=%h want=%h", got, exp_all); end
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(1'b1, 1'b1, 8'h83, 8'h83, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1);
    total++; if ({ctrl_a, ctrl_b, rd_a} !== 24'hA4A4A4) begin bad++; $display("FAIL rstmid_vals got=%h want=a4a4a4", {ctrl_a, ctrl_b, rd_a}); end
    total++; if ({busy_a, busy_b} !== 2'b00) begin bad++; $display("FAIL rstmid_busy got=%b want=00", {busy_a, busy_b}); end
    drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
    drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    total++; if ({ctrl_a, busy_a} !== 9'h148) begin bad++; $display("FAIL rstmid_load got=%h want=148", {ctrl_a, busy_a}); end
    total++; if (got !== exp_all) begin bad++; $display("FAIL rstmid_model got=%h want=%h", got, exp_all); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 39) != 0), $urandom_range(0, 1) == 1,
            8'($urandom), 8'($urandom), $urandom_range(0, 3) == 0);
      total++; if (got !== exp_all) begin bad++; $display("FAIL random_%0d got=%h want=%h", n, got, exp_all); end
    end
  endtask

  initial begin
    test_reset();
    test_direct_sync();
    test_toggle_mask();
    test_pulse_retrigger();
    test_double_buffer();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_reg_multi.md
# control_reg_multi

Parametrised successor to the fixed 8-bit UDB control register. It provides 1–32 firmware-writable control outputs with per-bit output mode (direct, synchronised, toggle, pulse) and a shadow/active double buffer, so several bits can be committed atomically. Optional auto-load makes it behave as a single-stage register. It sits between the CPU bus-write decode and the component datapaths it steers: counters, muxes and enables.

## Interface
- `Width`, default 8 — number of control bits, 1..32.
- `InitValue`, default 0 — reset value of the shadow and active registers; bits above `Width` are ignored.
- `ModeVec`, default 0 — 2·`Width` bits, 2 bits per output bit i at [2i+1:2i]:
  - 0 = DIRECT
  - 1 = SYNC
  - 2 = TOGGLE
  - 3 = PULSE
- `PulseWidth`, default 1 — high time of a PULSE-mode output, in cycles, 1..255.
- `AutoLoad`, default 1 — 1: active register follows shadow every cycle; 0: active register updates only on `load`.

Ports:
- `clock` in 1 — single clock.
- `reset` in 1 — synchronous, active-low.
- `wr_en` in 1 — write strobe, one cycle.
- `wr_data` in `Width` — write value.
- `wr_mask` in `Width` — per-bit write enable; 1 = bit is written.
- `load` in 1 — commit shadow to active; ignored when `AutoLoad`=1.
- `control` out `Width` — control outputs.
- `rd_data` out `Width` — shadow readback.
- `pulse_busy` out 1 — OR of all PULSE-mode counters being nonzero.

## Operation
- Shadow write: on `wr_en`, for each bit with `wr_mask`=1:
  - DIRECT/SYNC: shadow ← `wr_data`.
  - TOGGLE: `wr_data`=1 inverts shadow; 0 leaves it unchanged.
  - PULSE: `wr_data`=1 sets a pending flag; 0 does nothing. Shadow bit always reads 0.
- Commit happens when `AutoLoad`=1 (every cycle) or when `load`=1:
  - Active register takes the shadow value for DIRECT/SYNC/TOGGLE bits.
  - For PULSE bits with pending set: counter ← `PulseWidth`, then pending clears.
- Write and `load` in the same cycle: the commit uses the post-write shadow (write-through).
- PULSE output = (counter ≠ 0). The counter decrements each cycle while nonzero.
- A new commit of a PULSE bit while its counter ≠ 0 reloads `PulseWidth` (retrigger, no gap).
- Output stage:
  - DIRECT/TOGGLE: `control[i]` = active[i], registered.
  - SYNC: active[i] passes through one extra register stage.
- `rd_data` = shadow, registered. PULSE bits read 0. Readback is not affected by `load`.
- Masked-off bits and bits above `Width` are never modified.

## Timing
- Reset (`reset`=0 at an edge):
  - shadow, active ← `InitValue` with PULSE bits forced to 0.
  - pending and counters ← 0.
  - SYNC stage ← `InitValue`.
  - `control` = `InitValue` & ~PULSE-mask; `pulse_busy`=0.
- Reset overrides `wr_en` and `load` in the same cycle. Reset mid-pulse kills the pulse at the next edge.
- `AutoLoad`=1, write in cycle N:
  - DIRECT/TOGGLE `control` changes in N+1.
  - SYNC changes in N+2.
  - PULSE is high N+1 … N+`PulseWidth`; `pulse_busy` follows the same window.
- `AutoLoad`=0: write in N, `load` in M ≥ N. Outputs change in M+1 (M+2 for SYNC). Before that, `rd_data` already shows the new value in N+1.
- No backpressure: every `wr_en` and `load` is accepted.

## Structure
- Shared package `control_reg_pkg`:
  - mode encodings `CTRL_MODE_DIRECT`/`SYNC`/`TOGGLE`/`PULSE`.
  - `CTRL_MAX_WIDTH`=32.
  - `CTRL_PULSE_CNT_W`=8.
- One sub-module `control_reg_pulse_bit`: pending flag, 8-bit down-counter, retrigger logic. It is instantiated by generate for each bit with mode PULSE.
- Top level holds the shadow/active registers, the toggle logic and the SYNC stage.
- Parameter checks run at elaboration:
  - `Width` within 1..32.
  - `PulseWidth` within 1..255.
  - `ModeVec` width equals 2·`Width`.

## Test plan
- Reset: `Width`=8, `InitValue`=8'hA5, bit0 PULSE, others DIRECT. With `reset`=0 for 2 cycles, `control`=8'hA4, `rd_data`=8'hA4, `pulse_busy`=0.
- Direct/sync latency: bits[3:0] DIRECT, [7:4] SYNC, `AutoLoad`=1. Write 8'hFF with mask 8'hFF in cycle N. Expect `control`[3:0]=F at N+1 and [7:4]=F at N+2.
- Masking and toggle: all bits TOGGLE, shadow 8'h0F. Write 8'hFF with mask 8'h3C. Expect `rd_data`=8'h33, then writing the same value again gives 8'h0F.
- Pulse and retrigger: `PulseWidth`=4. Write bit0=1 in N, expect `control`[0] high N+1..N+4. Write again at N+2, expect high continuously to N+6.
- Double buffer: `AutoLoad`=0. Write 8'h3C, expect `rd_data`=8'h3C while `control` stays at the old value. Assert `load` at M, expect `control`=8'h3C at M+1. A write and `load` in the same cycle commits the new value.
- Reset mid-operation: during a pulse with counter=3 and a pending shadow write, assert `reset`. Next cycle expect `control`=`InitValue` & ~PULSE-mask and `pulse_busy`=0. After release, `load` alone changes nothing.
